// File: rtl/cflog_writer.sv
// cflog_writer -- control-flow log writer.
//
// Captures every control-flow transfer as a (source PC, destination PC) pair,
// queues it in a small FIFO and writes it word by word into the LOG region
// through a dedicated write port. When the next entry would not fit, the
// writer parks in W_FULL with trigger high until the TCB acknowledges, then
// restarts at word 0. Capture and FIFO pushes keep running while parked.
//
// Optional feature: define CFLOG_LOOP_COMPRESS_EN for 3-word entries
// (src, dst, count). A pair that repeats the last written pair only bumps
// that entry's count (saturating) instead of creating a new entry.
//
// Ports:
//   clk           system clock
//   reset         synchronous, active-high reset
//   pc            PC of the instruction at its boundary
//   pc_valid      pc holds a new instruction boundary this cycle
//   cf_event      instruction at pc is a control-flow transfer (with pc_valid)
//   trig_ack      TCB has consumed the log (only honoured in W_FULL)
//   log_wr_en     log write strobe, one cycle per word
//   log_wr_addr   byte address LOG_BASE + 2*index
//   log_wr_data   write data
//   trigger       log full, TCB service request
//   log_ptr       number of valid words in the log
//   log_overflow  sticky: a pair was dropped because the FIFO was full
module cflog_writer #(
  parameter logic [15:0] LOG_BASE   = 16'h01b0,
  parameter logic [15:0] LOG_SIZE   = 16'h0080,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] pc,
  input  logic        pc_valid,
  input  logic        cf_event,
  input  logic        trig_ack,
  output logic        log_wr_en,
  output logic [15:0] log_wr_addr,
  output logic [15:0] log_wr_data,
  output logic        trigger,
  output logic [15:0] log_ptr,
  output logic        log_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
`ifdef CFLOG_LOOP_COMPRESS_EN
  localparam logic [15:0] ENTRY_WORDS = 16'd3;
`else
  localparam logic [15:0] ENTRY_WORDS = 16'd2;
`endif

  typedef enum logic {C_IDLE, C_WAIT_DST} cap_state_e;
  typedef enum logic [2:0] {
    W_IDLE, W_SRC, W_DST,
`ifdef CFLOG_LOOP_COMPRESS_EN
    W_CNT,
`endif
    W_FULL
  } wr_state_e;

  function automatic logic [15:0] word_addr(input logic [15:0] idx);
    return LOG_BASE + (idx << 1);
  endfunction

  // ---------------- capture FSM ----------------
  cap_state_e  cap_q, cap_d;
  logic [15:0] src_q, src_d;
  logic        push;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    cap_d = cap_q;
    src_d = src_q;
    push  = 1'b0;
    case (cap_q)
      C_IDLE: if (pc_valid && cf_event) begin
        src_d = pc;
        cap_d = C_WAIT_DST;
      end
      C_WAIT_DST: if (pc_valid) begin
        push = 1'b1;
        // A transfer landing on another transfer starts the next pair here.
        if (cf_event) src_d = pc;
        else          cap_d = C_IDLE;
      end
      default: cap_d = C_IDLE;
    endcase
  end

  // ---------------- pending-pair FIFO ----------------
  logic [15:0] fifo_src_q [FIFO_DEPTH];
  logic [15:0] fifo_dst_q [FIFO_DEPTH];
  logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic        fifo_empty, fifo_full, pop, push_ok;
  logic        ovf_q, ovf_d;

  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = ((wptr_q - rptr_q) == DEPTH_C);
  // A pop in the same cycle frees the slot the push needs.
  assign push_ok    = push && (!fifo_full || pop);
  assign wptr_d     = push_ok ? wptr_q + PTR_ONE : wptr_q;
  assign rptr_d     = pop ? rptr_q + PTR_ONE : rptr_q;
  assign ovf_d      = ovf_q | (push && !push_ok);

  // NOTE: the storage array has no reset; the pointers alone say which slots are valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_src_q[wptr_q[AW-1:0]] <= src_q;
      fifo_dst_q[wptr_q[AW-1:0]] <= pc;
    end
  end

  logic [15:0] head_src, head_dst;
  assign head_src = fifo_src_q[rptr_q[AW-1:0]];
  assign head_dst = fifo_dst_q[rptr_q[AW-1:0]];

  // ---------------- writer FSM ----------------
  wr_state_e   wst_q, wst_d;
  logic [15:0] cur_src_q, cur_src_d, cur_dst_q, cur_dst_d;
  logic [15:0] ptr_q, ptr_d, addr_q, addr_d, data_q, data_d;
  logic        wr_en_q, wr_en_d, trig_q, trig_d;
  logic        no_room;
`ifdef CFLOG_LOOP_COMPRESS_EN
  logic        last_valid_q, last_valid_d, upd_q, upd_d;
  logic [15:0] last_src_q, last_src_d, last_dst_q, last_dst_d;
  logic [15:0] last_cnt_q, last_cnt_d;
`endif

  // Widened so the comparison cannot wrap for any LOG_SIZE.
  assign no_room = ({1'b0, ptr_q} + {1'b0, ENTRY_WORDS}) > {1'b0, LOG_SIZE};

  always_comb begin
    wst_d     = wst_q;
    pop       = 1'b0;
    cur_src_d = cur_src_q;
    cur_dst_d = cur_dst_q;
    ptr_d     = ptr_q;
    wr_en_d   = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    trig_d    = trig_q;
`ifdef CFLOG_LOOP_COMPRESS_EN
    last_valid_d = last_valid_q;
    last_src_d   = last_src_q;
    last_dst_d   = last_dst_q;
    last_cnt_d   = last_cnt_q;
    upd_d        = upd_q;
`endif
    case (wst_q)
      W_IDLE: if (!fifo_empty) begin
        if (no_room) begin
          wst_d  = W_FULL;
          trig_d = 1'b1;
        end else begin
          pop       = 1'b1;
          cur_src_d = head_src;
          cur_dst_d = head_dst;
`ifdef CFLOG_LOOP_COMPRESS_EN
          upd_d = last_valid_q && (head_src == last_src_q) && (head_dst == last_dst_q);
          wst_d = upd_d ? W_CNT : W_SRC;
`else
          wst_d = W_SRC;
`endif
        end
      end
      W_SRC: begin
        wr_en_d = 1'b1;
        addr_d  = word_addr(ptr_q);
        data_d  = cur_src_q;
        wst_d   = W_DST;
      end
      W_DST: begin
        wr_en_d = 1'b1;
        addr_d  = word_addr(ptr_q + 16'd1);
        data_d  = cur_dst_q;
`ifdef CFLOG_LOOP_COMPRESS_EN
        wst_d = W_CNT;
`else
        ptr_d = ptr_q + ENTRY_WORDS;
        wst_d = W_IDLE;
`endif
      end
`ifdef CFLOG_LOOP_COMPRESS_EN
      W_CNT: begin
        wr_en_d = 1'b1;
        wst_d   = W_IDLE;
        if (upd_q) begin
          // Rewrite the count of the most recent entry, which ends at ptr-1.
          last_cnt_d = (last_cnt_q == 16'hFFFF) ? 16'hFFFF : last_cnt_q + 16'd1;
          addr_d     = word_addr(ptr_q - 16'd1);
          data_d     = last_cnt_d;
        end else begin
          last_cnt_d   = 16'd1;
          addr_d       = word_addr(ptr_q + 16'd2);
          data_d       = 16'd1;
          last_valid_d = 1'b1;
          last_src_d   = cur_src_q;
          last_dst_d   = cur_dst_q;
          ptr_d        = ptr_q + ENTRY_WORDS;
        end
      end
`endif
      W_FULL: if (trig_ack) begin
        ptr_d  = 16'd0;
        trig_d = 1'b0;
        wst_d  = W_IDLE;
`ifdef CFLOG_LOOP_COMPRESS_EN
        last_valid_d = 1'b0;
`endif
      end
      default: wst_d = W_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      cap_q     <= C_IDLE;
      src_q     <= 16'd0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      ovf_q     <= 1'b0;
      wst_q     <= W_IDLE;
      cur_src_q <= 16'd0;
      cur_dst_q <= 16'd0;
      ptr_q     <= 16'd0;
      wr_en_q   <= 1'b0;
      addr_q    <= 16'd0;
      data_q    <= 16'd0;
      trig_q    <= 1'b0;
`ifdef CFLOG_LOOP_COMPRESS_EN
      last_valid_q <= 1'b0;
      last_src_q   <= 16'd0;
      last_dst_q   <= 16'd0;
      last_cnt_q   <= 16'd0;
      upd_q        <= 1'b0;
`endif
    end else begin
      cap_q     <= cap_d;
      src_q     <= src_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      ovf_q     <= ovf_d;
      wst_q     <= wst_d;
      cur_src_q <= cur_src_d;
      cur_dst_q <= cur_dst_d;
      ptr_q     <= ptr_d;
      wr_en_q   <= wr_en_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      trig_q    <= trig_d;
`ifdef CFLOG_LOOP_COMPRESS_EN
      last_valid_q <= last_valid_d;
      last_src_q   <= last_src_d;
      last_dst_q   <= last_dst_d;
      last_cnt_q   <= last_cnt_d;
      upd_q        <= upd_d;
`endif
    end
  end

  assign log_wr_en    = wr_en_q;
  assign log_wr_addr  = addr_q;
  assign log_wr_data  = data_q;
  assign trigger      = trig_q;
  assign log_ptr      = ptr_q;
  assign log_overflow = ovf_q;

endmodule

// File: tb/tb_cflog_writer.sv
// Self-checking bench for cflog_writer. A log-level reference model turns
// each captured (src,dst) pair into the sequence of log writes it must
// produce; a monitor compares every observed write strobe against it.
module tb_cflog_writer;

  localparam logic [15:0] LOG_BASE = 16'h01b0;
  localparam logic [15:0] LOG_SIZE = 16'h0080;
`ifdef CFLOG_LOOP_COMPRESS_EN
  localparam bit COMPRESS = 1'b1;
  localparam int EW       = 3;
`else
  localparam bit COMPRESS = 1'b0;
  localparam int EW       = 2;
`endif
  localparam int N_FILL   = int'(LOG_SIZE) / EW;
  localparam int FULL_PTR = N_FILL * EW;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] pc = 16'h0000;
  logic        pc_valid = 1'b0;
  logic        cf_event = 1'b0;
  logic        trig_ack = 1'b0;
  logic        log_wr_en;
  logic [15:0] log_wr_addr;
  logic [15:0] log_wr_data;
  logic        trigger;
  logic [15:0] log_ptr;
  logic        log_overflow;

  cflog_writer #(.LOG_BASE(LOG_BASE), .LOG_SIZE(LOG_SIZE), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .pc(pc), .pc_valid(pc_valid), .cf_event(cf_event),
    .trig_ack(trig_ack), .log_wr_en(log_wr_en), .log_wr_addr(log_wr_addr),
    .log_wr_data(log_wr_data), .trigger(trigger), .log_ptr(log_ptr),
    .log_overflow(log_overflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // ---------------- reference model ----------------
  logic [31:0] exp_q[$];          // {addr, data} of each expected write, in order
  int          m_ptr = 0;
  bit          m_lv = 1'b0;
  logic [15:0] m_ls, m_ld;
  int          m_lc;

  function automatic logic [31:0] wr(input int idx, input int data);
    logic [15:0] a, d;
    a = 16'(int'(LOG_BASE) + 2 * idx);
    d = 16'(data);
    return {a, d};
  endfunction

  function automatic void model_pair(input logic [15:0] s, input logic [15:0] d);
    if (COMPRESS && m_lv && s == m_ls && d == m_ld) begin
      m_lc = (m_lc >= 65535) ? 65535 : m_lc + 1;
      exp_q.push_back(wr(m_ptr - 1, m_lc));
    end else begin
      exp_q.push_back(wr(m_ptr, int'(s)));
      exp_q.push_back(wr(m_ptr + 1, int'(d)));
      if (COMPRESS) begin
        exp_q.push_back(wr(m_ptr + 2, 1));
        m_lv = 1'b1;
        m_ls = s;
        m_ld = d;
        m_lc = 1;
      end
      m_ptr += EW;
    end
  endfunction

  function automatic void model_ack();
    m_ptr = 0;
    m_lv  = 1'b0;
  endfunction

  // ---------------- write monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (log_wr_en === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%h data=%h (no write expected)", log_wr_addr, log_wr_data);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if ({log_wr_addr, log_wr_data} !== e)
          begin
            errors++;
            $display("FAIL log_write got addr=%h data=%h exp addr=%h data=%h",
                     log_wr_addr, log_wr_data, e[31:16], e[15:0]);
          end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic boundary(input logic [15:0] p, input logic cf);
    pc = p; pc_valid = 1'b1; cf_event = cf;
    step();
    pc_valid = 1'b0; cf_event = 1'b0; pc = 16'($urandom);
  endtask

  task automatic send_pair(input logic [15:0] s, input logic [15:0] d);
    boundary(s, 1'b1);
    idle(1);
    boundary(d, 1'b0);
    idle(2);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    exp_q.delete();
    model_ack();
  endtask

  task automatic fill_log();
    for (int i = 0; i < N_FILL; i++) begin
      model_pair(16'h1000 + 16'(i), 16'h8000 + 16'(i));
      send_pair(16'h1000 + 16'(i), 16'h8000 + 16'(i));
    end
    idle(10);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    idle(3);
    checks++; if (log_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got=%b exp=0", log_wr_en); end
    checks++; if (log_wr_addr !== 16'h0000) begin errors++; $display("FAIL reset_addr got=%h exp=0000", log_wr_addr); end
    checks++; if (log_wr_data !== 16'h0000) begin errors++; $display("FAIL reset_data got=%h exp=0000", log_wr_data); end
    checks++; if (trigger !== 1'b0) begin errors++; $display("FAIL reset_trigger got=%b exp=0", trigger); end
    checks++; if (log_ptr !== 16'h0000) begin errors++; $display("FAIL reset_ptr got=%h exp=0000", log_ptr); end
    checks++; if (log_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", log_overflow); end
    reset = 1'b0;
    exp_q.delete();
    model_ack();
  endtask

  task automatic test_single();
    model_pair(16'hE010, 16'hE200);
    boundary(16'hE010, 1'b1);
    idle(1);
    boundary(16'hE200, 1'b0);         // pair pushed at this edge (N)
    step();                           // N+1: pair popped, nothing written yet
    checks++; if (log_wr_en !== 1'b0) begin errors++; $display("FAIL single_lat_n1 wr_en got=%b exp=0", log_wr_en); end
    step();                           // N+2: src strobe
    checks++; if (log_wr_en !== 1'b1 || log_wr_addr !== 16'h01b0)
      begin errors++; $display("FAIL single_src_strobe en=%b addr=%h exp en=1 addr=01b0", log_wr_en, log_wr_addr); end
    step();                           // N+3: dst strobe
    checks++; if (log_wr_en !== 1'b1 || log_wr_addr !== 16'h01b2)
      begin errors++; $display("FAIL single_dst_strobe en=%b addr=%h exp en=1 addr=01b2", log_wr_en, log_wr_addr); end
    idle(6);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL single_writes_left got=%0d exp=0", exp_q.size()); end
    checks++; if (log_ptr !== 16'(m_ptr)) begin errors++; $display("FAIL single_ptr got=%0d exp=%0d", log_ptr, m_ptr); end
    // trig_ack outside W_FULL must be ignored.
    trig_ack = 1'b1;
    step();
    trig_ack = 1'b0;
    idle(2);
    checks++; if (log_ptr !== 16'(m_ptr) || trigger !== 1'b0)
      begin errors++; $display("FAIL ack_ignored ptr=%0d trig=%b exp ptr=%0d trig=0", log_ptr, trigger, m_ptr); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    model_pair(16'hE010, 16'hE200);
    model_pair(16'hE200, 16'hE300);
    boundary(16'hE010, 1'b1);
    idle(1);
    boundary(16'hE200, 1'b1);
    idle(1);
    boundary(16'hE300, 1'b0);
    idle(20);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_writes_left got=%0d exp=0", exp_q.size()); end
    checks++; if (log_ptr !== 16'(m_ptr)) begin errors++; $display("FAIL b2b_ptr got=%0d exp=%0d", log_ptr, m_ptr); end
  endtask

  task automatic test_repeat();
    do_reset();
    repeat (3) begin
      model_pair(16'hE010, 16'hE000);
      send_pair(16'hE010, 16'hE000);
    end
    idle(20);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL repeat_writes_left got=%0d exp=0", exp_q.size()); end
    checks++; if (log_ptr !== 16'(m_ptr)) begin errors++; $display("FAIL repeat_ptr got=%0d exp=%0d", log_ptr, m_ptr); end
  endtask

  task automatic test_random();
    logic [15:0] pool [4];
    logic [15:0] prev_pc, p;
    bit          prev_cf, cf;
    do_reset();
    foreach (pool[i]) pool[i] = 16'($urandom);
    prev_cf = 1'b0;
    prev_pc = 16'h0000;
    for (int i = 0; i < 30; i++) begin
      p  = pool[$urandom_range(0, 3)];
      cf = 1'($urandom_range(0, 1));
      // Every boundary that follows a transfer closes a pair.
      if (prev_cf) model_pair(prev_pc, p);
      boundary(p, cf);
      idle($urandom_range(4, 6));
      prev_cf = cf;
      prev_pc = p;
    end
    idle(30);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL random_writes_left got=%0d exp=0", exp_q.size()); end
    checks++; if (log_ptr !== 16'(m_ptr)) begin errors++; $display("FAIL random_ptr got=%0d exp=%0d", log_ptr, m_ptr); end
  endtask

  task automatic test_fill_overflow();
    do_reset();
    fill_log();
    checks++; if (log_ptr !== 16'(FULL_PTR)) begin errors++; $display("FAIL fill_ptr got=%0d exp=%0d", log_ptr, FULL_PTR); end
    checks++; if (trigger !== 1'b0) begin errors++; $display("FAIL fill_trig_early got=%b exp=0", trigger); end
    model_ack();
    for (int i = N_FILL; i < N_FILL + 4; i++) model_pair(16'h1000 + 16'(i), 16'h8000 + 16'(i));
    send_pair(16'h1000 + 16'(N_FILL), 16'h8000 + 16'(N_FILL));
    for (int k = 0; k < 10 && trigger !== 1'b1; k++) step();
    checks++; if (trigger !== 1'b1) begin errors++; $display("FAIL fill_trigger got=%b exp=1", trigger); end
    checks++; if (log_ptr !== 16'(FULL_PTR)) begin errors++; $display("FAIL full_ptr got=%0d exp=%0d", log_ptr, FULL_PTR); end
    idle(5);
    checks++; if (trigger !== 1'b1) begin errors++; $display("FAIL trig_hold got=%b exp=1", trigger); end
    for (int i = N_FILL + 1; i < N_FILL + 5; i++) send_pair(16'h1000 + 16'(i), 16'h8000 + 16'(i));
    checks++; if (log_overflow !== 1'b1) begin errors++; $display("FAIL overflow_set got=%b exp=1", log_overflow); end
    checks++; if (exp_q.size() != 4 * EW) begin errors++; $display("FAIL write_while_full pending=%0d exp=%0d", exp_q.size(), 4 * EW); end
    trig_ack = 1'b1;
    step();
    trig_ack = 1'b0;
    checks++; if (trigger !== 1'b0 || log_ptr !== 16'h0000)
      begin errors++; $display("FAIL ack_clear trig=%b ptr=%0d exp trig=0 ptr=0", trigger, log_ptr); end
    idle(40);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL drain_after_ack got=%0d exp=0", exp_q.size()); end
    checks++; if (log_ptr !== 16'(m_ptr)) begin errors++; $display("FAIL post_ack_ptr got=%0d exp=%0d", log_ptr, m_ptr); end
    checks++; if (log_overflow !== 1'b1) begin errors++; $display("FAIL overflow_sticky got=%b exp=1", log_overflow); end
  endtask

  task automatic test_ack_same_cycle();
    bit found;
    do_reset();
    fill_log();
    model_ack();
    model_pair(16'hAA00, 16'hBB00);
    boundary(16'hAA00, 1'b1);
    idle(1);
    boundary(16'hBB00, 1'b0);
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (trigger === 1'b1) begin found = 1'b1; break; end
      step();
    end
    checks++; if (!found) begin errors++; $display("FAIL same_cycle_trigger_timeout got=0 exp=1"); end
    trig_ack = 1'b1;                  // asserted in the first cycle trigger is high
    step();
    trig_ack = 1'b0;
    checks++; if (trigger !== 1'b0 || log_ptr !== 16'h0000)
      begin errors++; $display("FAIL same_cycle_ack trig=%b ptr=%0d exp trig=0 ptr=0", trigger, log_ptr); end
    idle(20);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL same_cycle_drain got=%0d exp=0", exp_q.size()); end
    checks++; if (log_ptr !== 16'(m_ptr)) begin errors++; $display("FAIL same_cycle_ptr got=%0d exp=%0d", log_ptr, m_ptr); end
  endtask

  task automatic test_reset_mid_entry();
    bit found;
    do_reset();
    model_pair(16'hE010, 16'hE200);
    boundary(16'hE010, 1'b1);
    idle(1);
    boundary(16'hE200, 1'b0);
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (log_wr_en === 1'b1) begin found = 1'b1; break; end
      step();
    end
    checks++; if (!found) begin errors++; $display("FAIL mid_src_timeout got=0 exp=1"); end
    reset = 1'b1;                     // writer is now in W_DST
    step();
    reset = 1'b0;
    checks++; if ({log_wr_en, log_wr_addr, log_wr_data, trigger, log_ptr, log_overflow} !== 51'd0)
      begin errors++; $display("FAIL mid_reset_outputs en=%b addr=%h data=%h trig=%b ptr=%h ovf=%b exp all 0",
                               log_wr_en, log_wr_addr, log_wr_data, trigger, log_ptr, log_overflow); end
    idle(8);
    checks++; if (exp_q.size() != 1) begin errors++; $display("FAIL mid_reset_dst_written pending=%0d exp=1", exp_q.size()); end
    exp_q.delete();
    model_ack();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_repeat();
    test_random();
    test_fill_overflow();
    test_ack_same_cycle();
    test_reset_mid_entry();
    idle(5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
